// File: rtl/muldiv_pkg.sv
// Shared RV32M multiply/divide definitions: operand width, Funct3 op
// encoding and the iterative unit's state encoding (also used by decode).
package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on magnitudes, sign-fixed in a final cycle.
// Ports: clk, reset (async active-low), start, flush, Funct3, SrcA, SrcB
// in; busy (stall), done (1-cycle result pulse), Result out.
module mul_div_unit #(
    parameter int XLEN = muldiv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] Result
);
    import muldiv_pkg::*;

    localparam int CW = $clog2(XLEN);

    state_e            r_state;
    logic [2:0]        r_op;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [XLEN:0]     r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_b;
    logic [CW-1:0]     r_cnt;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    logic              w_sa;
    logic              w_sb;
    logic              w_na;
    logic              w_nb;
    logic [XLEN-1:0]   w_ma;
    logic [XLEN-1:0]   w_mb;
    logic              w_dz;
    logic              w_ov;
    logic [XLEN-1:0]   w_spec;
    logic              w_div;
    logic [XLEN:0]     w_opa;
    logic [XLEN:0]     w_opb;
    logic [XLEN+1:0]   w_sum;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix;

    // operand signedness of the incoming request
    always_comb begin
        w_sa = 1'b0;
        w_sb = 1'b0;
        unique case (Funct3)
            OP_MULH, OP_DIV, OP_REM: begin
                w_sa = 1'b1;
                w_sb = 1'b1;
            end
            OP_MULHSU: w_sa = 1'b1;
            default: ;
        endcase
    end

    assign w_na = w_sa & SrcA[XLEN-1];
    assign w_nb = w_sb & SrcB[XLEN-1];
    assign w_ma = w_na ? -SrcA : SrcA;
    assign w_mb = w_nb ? -SrcB : SrcB;

    assign w_dz = Funct3[2] && (SrcB == '0);
    assign w_ov = (Funct3 == OP_DIV || Funct3 == OP_REM)
               && (SrcA == {1'b1, {(XLEN-1){1'b0}}})
               && (SrcB == '1);

    // Funct3[1] selects remainder among the divide ops
    always_comb begin
        if (w_dz)
            w_spec = Funct3[1] ? SrcA : '1;
        else
            w_spec = Funct3[1] ? '0 : SrcA;
    end

    // Shared adder: multiply adds the multiplicand when the low
    // multiplier bit is set; divide subtracts the divisor from the
    // shifted partial remainder, carry-out meaning "fits".
    assign w_div = r_op[2];
    assign w_opa = w_div ? {r_hi[XLEN-1:0], r_lo[XLEN-1]} : r_hi;
    assign w_opb = w_div ? ~{1'b0, r_b}
                 : (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_sum = {1'b0, w_opa} + {1'b0, w_opb}
                 + {{(XLEN+1){1'b0}}, w_div};

    assign w_prod   = {r_hi[XLEN-1:0], r_lo};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quo    = r_neg_q ? -r_lo : r_lo;
    assign w_rem    = r_neg_r ? -r_hi[XLEN-1:0] : r_hi[XLEN-1:0];

    always_comb begin
        w_fix = w_rem;
        unique case (r_op)
            OP_MUL:                       w_fix = w_prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix = w_prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_fix = w_quo;
            default:                      w_fix = w_rem;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= Funct3;
                        r_neg_q <= w_na ^ w_nb;
                        r_neg_r <= w_na;
                        r_hi    <= '0;
                        r_lo    <= w_ma;
                        r_b     <= w_mb;
                        r_cnt   <= '0;
                        if (w_dz || w_ov) begin
                            r_result <= w_spec;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (w_div) begin
                        if (w_sum[XLEN+1]) begin
                            r_hi <= w_sum[XLEN:0];
                            r_lo <= {r_lo[XLEN-2:0], 1'b1};
                        end else begin
                            r_hi <= w_opa;
                            r_lo <= {r_lo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        r_hi <= {1'b0, w_sum[XLEN:1]};
                        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
                    end
                    if (r_cnt == CW'(XLEN-1)) begin
                        r_cnt   <= '0;
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign Result = r_result;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed RV32M cases, flush,
// reset and back-to-back behaviour, then random ops vs an arithmetic model.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  Funct3;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        busy;
    logic        done;
    logic [31:0] Result;

    int checks;
    int failures;
    logic [31:0] last_res;

    mul_div_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .busy   (busy),
        .done   (done),
        .Result (Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_special(input logic [2:0] f,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        if (!f[2]) return 1'b0;
        if (b == 32'd0) return 1'b1;
        return (f == 3'b100 || f == 3'b110)
            && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] ref_f(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        p  = '0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // Issue one op, follow it to done, check latency, busy profile,
    // result, single-cycle done and result hold. Ends in the IDLE cycle
    // after DONE so the next call starts back-to-back.
    task automatic run_op(input string tag, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input int glitch);
        logic [31:0] exp;
        int lat, n, bad;
        exp = ref_f(f, a, b);
        lat = is_special(f, a, b) ? 1 : 34;
        Funct3 = f; SrcA = a; SrcB = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1; bad = 0;
        while (n < 60) begin
            if (done === 1'b1) break;
            if (busy !== 1'b1) bad++;
            if (n == glitch) begin
                start = 1'b1; SrcA = ~a; SrcB = b + 32'd1; Funct3 = ~f;
            end else begin
                start = 1'b0; SrcA = a; SrcB = b; Funct3 = f;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_busyprof"}, 32'(bad), 32'd0);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_res"}, Result, exp);
        @(posedge clk); #1;
        check({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
        check({tag, "_hold"}, Result, exp);
        last_res = exp;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cnt;
        checks = 0; failures = 0; last_res = '0;
        reset = 1'b0; start = 1'b0; flush = 1'b0;
        Funct3 = '0; SrcA = '0; SrcB = '0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", Result, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        run_op("mul_3x4", 3'b000, 32'd3, 32'd4, 0);
        run_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("div_7_m2", 3'b100, 32'd7, 32'hFFFF_FFFE, 0);
        run_op("rem_7_m2", 3'b110, 32'd7, 32'hFFFF_FFFE, 0);
        run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("divu_5_0", 3'b101, 32'd5, 32'd0, 0);
        run_op("remu_5_0", 3'b111, 32'd5, 32'd0, 0);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("div_ignore_start", 3'b100, 32'd1000, 32'd7, 5);

        // flush mid-divide
        Funct3 = 3'b100; SrcA = 32'd100; SrcB = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("flush_pre_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_hold", Result, last_res);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) cnt++;
            @(posedge clk); #1;
        end
        check("flush_no_done", 32'(cnt), 32'd0);
        run_op("mul_after_flush", 3'b000, 32'h0001_2345, 32'hFFFF_FFF3, 0);

        // flush and start together: request dropped
        Funct3 = 3'b000; SrcA = 32'd9; SrcB = 32'd9;
        start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1 || busy === 1'b1) cnt++;
            @(posedge clk); #1;
        end
        check("flush_start_drop", 32'(cnt), 32'd0);
        check("flush_start_hold", Result, last_res);

        // reset mid-multiply
        Funct3 = 3'b000; SrcA = 32'd11; SrcB = 32'd13; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_done", {31'd0, done}, 32'd0);
        check("rstmid_result", Result, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) cnt++;
            @(posedge clk); #1;
        end
        check("rstmid_no_done", 32'(cnt), 32'd0);

        for (int k = 0; k < 40; k++) begin
            logic [2:0] f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op($sformatf("rand%0d_f%0d", k, f), f, a, b, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
